// File: rtl/scb_result_writer.sv
// Result writer: snapshots the multiplier's product polynomial when res_valid
// rises in IDLE, then streams it out one coefficient per valid/ready beat.
module scb_result_writer #(
  parameter int unsigned N_COEFF = 256,
  parameter int unsigned COEFF_W = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         res_valid,
  input  logic [N_COEFF*COEFF_W-1:0]   res_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COEFF_W-1:0]           out_data,
  output logic [7:0]                   out_addr,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned DATA_W = N_COEFF * COEFF_W;
  localparam int unsigned ADDR_W = 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_COEFF - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StStream  = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   w_hold_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_next;
  logic                w_beat;
  logic                w_last_idx;

  // out_ready only matters while streaming
  assign w_beat     = (r_state == StStream) && out_ready;
  assign w_last_idx = (r_idx == LAST_IDX);

  // Next-state: DONE waits for res_valid to drop so a held level cannot retrigger
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (res_valid) w_state_next = StCapture;
      StCapture: w_state_next = StStream;
      StStream:  if (w_beat && w_last_idx) w_state_next = StDone;
      StDone:    if (!res_valid) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Datapath: load snapshot in IDLE, shift out one coefficient per beat
  always_comb begin
    w_hold_next = r_hold;
    w_idx_next  = r_idx;
    if ((r_state == StIdle) && res_valid) begin
      w_hold_next = res_data;
      w_idx_next  = '0;
    end else if (w_beat) begin
      w_hold_next = r_hold >> COEFF_W;
      // Index parks on the last address instead of wrapping
      if (!w_last_idx) w_idx_next = r_idx + 1'b1;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_idx   <= w_idx_next;
    end
  end

  // Outputs decode straight from registers so reset clears them without a clock
  always_comb begin
    out_valid = (r_state == StStream);
    out_data  = r_hold[COEFF_W-1:0];
    out_addr  = r_idx;
    out_last  = (r_state == StStream) && w_last_idx;
    busy      = (r_state == StCapture) || (r_state == StStream);
    done      = (r_state == StDone);
  end

endmodule

// File: tb/tb_scb_result_writer.sv
// Directed bench for scb_result_writer: vector table plus multi-cycle sequences.
module tb_scb_result_writer;

  localparam int N = 256;
  localparam int W = 13;

  logic           clk;
  logic           rst;
  logic           res_valid;
  logic [N*W-1:0] res_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [7:0]     out_addr;
  logic           out_last;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_coef [N];

  typedef struct {
    logic rv;
    logic rdy;
    logic e_valid;
    int   e_addr;
    int   e_data;
    logic e_last;
    logic e_busy;
    logic e_done;
  } vec_t;

  vec_t vecs [8];
  logic pat [4];

  scb_result_writer dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // kind 0: coefficient i = i+1; kind 1: c0 = 0, c255 = 0x1FFF, others scrambled
  task automatic set_pattern(input int kind);
    for (int i = 0; i < N; i++) begin
      if (kind == 0) exp_coef[i] = i + 1;
      else if (i == 0) exp_coef[i] = 0;
      else if (i == N - 1) exp_coef[i] = 13'h1FFF;
      else exp_coef[i] = (i * 4099 + 7) & 13'h1FFF;
      res_data[i*W +: W] = W'(exp_coef[i]);
    end
  endtask

  // Consume beats until done, checking each presented beat against the model.
  // cyc0 is the cycle number of the current sample point.
  task automatic drain(input int first_addr, input bit stall, input int cyc0,
                       output int first_cyc, output int last_cyc, output int done_cyc);
    int addr;
    int cyc;
    int ph;
    addr = first_addr;
    cyc = cyc0;
    ph = 0;
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
    while (done !== 1'b1 && cyc < cyc0 + 2000) begin
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        check("beat_addr", 32'(out_addr), 32'(addr));
        check("beat_data", 32'(out_data), (addr < N) ? 32'(exp_coef[addr]) : 32'hDEAD);
        check("beat_last", 32'(out_last), 32'(addr == N - 1));
        out_ready = stall ? pat[ph % 4] : 1'b1;
        ph++;
        if (out_ready) begin
          if (addr == N - 1) last_cyc = cyc;
          addr++;
        end
      end
      tick();
      cyc++;
    end
    if (done === 1'b1) done_cyc = cyc;
    check("beats_total", 32'(addr), 32'(N));
    check("done_reached", 32'(done), 32'd1);
    out_ready = 1'b1;
  endtask

  int f_cyc;
  int l_cyc;
  int d_cyc;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    //               rv    rdy   valid addr data last  busy  done
    vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1, 2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2, 3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2, 3, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 2, 3, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3, 4, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    res_valid = 1'b0;
    out_ready = 1'b0;
    set_pattern(0);
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Vector table: capture, ignored ready in CAPTURE, stalls, ignored res_valid
    for (int i = 0; i < 8; i++) begin
      res_valid = vecs[i].rv;
      out_ready = vecs[i].rdy;
      tick();
      if (i == 0) res_data = '1;  // snapshot must survive input change
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].e_last));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
    end
    res_valid = 1'b0;
    drain(3, 1'b1, 0, f_cyc, l_cyc, d_cyc);
    check("stall_done_valid", 32'(out_valid), 32'd0);
    check("stall_done_busy", 32'(busy), 32'd0);
    tick();
    check("idle_after_done", 32'(done), 32'd0);

    // Full-rate stream and latency
    set_pattern(0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("cap_busy", 32'(busy), 32'd1);
    check("cap_valid", 32'(out_valid), 32'd0);
    drain(0, 1'b0, 1, f_cyc, l_cyc, d_cyc);
    check("lat_first", 32'(f_cyc), 32'd2);
    check("lat_last", 32'(l_cyc), 32'd257);
    check("lat_done", 32'(d_cyc), 32'd258);
    tick();
    check("lat_idle_done", 32'(done), 32'd0);

    // Boundary coefficients with res_valid held high through DONE
    set_pattern(1);
    res_valid = 1'b1;
    tick();
    drain(0, 1'b0, 1, f_cyc, l_cyc, d_cyc);
    for (int k = 0; k < 5; k++) tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_no_restream", 32'(out_valid), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    res_valid = 1'b0;
    tick();
    check("drop_done", 32'(done), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    res_valid = 1'b1;
    tick();
    check("second_cap_busy", 32'(busy), 32'd1);
    res_valid = 1'b0;
    drain(0, 1'b0, 1, f_cyc, l_cyc, d_cyc);
    check("second_first", 32'(f_cyc), 32'd2);
    tick();

    // Asynchronous reset at beat 100
    set_pattern(0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && !(out_valid === 1'b1 && out_addr == 8'd100); k++) tick();
    check("reach_beat100", 32'(out_addr), 32'd100);
    check("reach_data100", 32'(out_data), 32'd101);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_addr", 32'(out_addr), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    drain(0, 1'b0, 1, f_cyc, l_cyc, d_cyc);
    check("restart_first", 32'(f_cyc), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
